// File: rtl/average_unpooling.sv
// Nearest-neighbour unpooling engine: reads a DxD map from scratchpad memory and
// writes each word back as a PxP block of a (D*P)x(D*P) map. Start/done handshake.
module average_unpooling #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DIM_WIDTH-1:0]  pool_size,
    input  logic [ADDR_WIDTH-1:0] input_addr,
    input  logic [ADDR_WIDTH-1:0] output_addr,
    input  logic [DIM_WIDTH-1:0]  dimensions,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data
);

    localparam int PW = 2*DIM_WIDTH + ADDR_WIDTH;

    typedef logic [DIM_WIDTH-1:0]  dim_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [PW-1:0]         wide_t;

    typedef struct packed {
        dim_t  p;
        dim_t  d;
        addr_t ia;
        addr_t oa;
    } job_t;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WRITE, DONE} state_t;

    state_t                state, nxt_state;
    job_t                  job, nxt_job;
    dim_t                  r, c, i, j;
    dim_t                  nxt_r, nxt_c, nxt_i, nxt_j;
    dim_t                  p_last, d_last;
    logic [DATA_WIDTH-1:0] hold, nxt_hold;
    logic                  accept;
    wide_t                 rd_full, wr_full, row_words;

    // Next-state and next-counter values; memory outputs are registered from these
    // so that each request appears in the same cycle as the state that owns it.
    always_comb begin
        accept    = (state == IDLE) && !busy && valid_in;
        nxt_state = state;
        nxt_job   = job;
        nxt_r     = r;
        nxt_c     = c;
        nxt_i     = i;
        nxt_j     = j;
        nxt_hold  = hold;
        p_last    = job.p - 1'b1;
        d_last    = job.d - 1'b1;

        case (state)
            IDLE: begin
                if (accept) begin
                    nxt_job = '{p: pool_size, d: dimensions, ia: input_addr, oa: output_addr};
                    nxt_r   = '0;
                    nxt_c   = '0;
                    nxt_i   = '0;
                    nxt_j   = '0;
                    nxt_state = (pool_size == '0 || dimensions == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: nxt_state = RD_WAIT;
            RD_WAIT: begin
                nxt_hold  = mem_rd_data;
                nxt_i     = '0;
                nxt_j     = '0;
                nxt_state = WRITE;
            end
            WRITE: begin
                if (j != p_last) begin
                    nxt_j = j + 1'b1;
                end else begin
                    nxt_j = '0;
                    if (i != p_last) begin
                        nxt_i = i + 1'b1;
                    end else begin
                        nxt_i = '0;
                        if (c != d_last) begin
                            nxt_c     = c + 1'b1;
                            nxt_state = RD_REQ;
                        end else begin
                            nxt_c = '0;
                            if (r != d_last) begin
                                nxt_r     = r + 1'b1;
                                nxt_state = RD_REQ;
                            end else begin
                                nxt_state = DONE;
                            end
                        end
                    end
                end
            end
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase

        // Wide intermediates; only the low ADDR_WIDTH bits are used, so addresses wrap.
        row_words = wide_t'(nxt_job.d) * wide_t'(nxt_job.p);
        rd_full   = wide_t'(nxt_job.ia) + wide_t'(nxt_r) * wide_t'(nxt_job.d) + wide_t'(nxt_c);
        wr_full   = wide_t'(nxt_job.oa)
                  + (wide_t'(nxt_r) * wide_t'(nxt_job.p) + wide_t'(nxt_i)) * row_words
                  + wide_t'(nxt_c) * wide_t'(nxt_job.p) + wide_t'(nxt_j);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            job         <= '0;
            r           <= '0;
            c           <= '0;
            i           <= '0;
            j           <= '0;
            hold        <= '0;
            valid_out   <= 1'b0;
            busy        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            state <= nxt_state;
            job   <= nxt_job;
            r     <= nxt_r;
            c     <= nxt_c;
            i     <= nxt_i;
            j     <= nxt_j;
            hold  <= nxt_hold;

            mem_rd_en   <= (nxt_state == RD_REQ);
            mem_rd_addr <= (nxt_state == RD_REQ) ? rd_full[ADDR_WIDTH-1:0] : '0;
            mem_wr_en   <= (nxt_state == WRITE);
            mem_wr_addr <= (nxt_state == WRITE) ? wr_full[ADDR_WIDTH-1:0] : '0;
            mem_wr_data <= (nxt_state == WRITE) ? nxt_hold : '0;

            valid_out <= (state == DONE);
            // busy covers the done pulse cycle, so a start during it is ignored.
            if (accept)
                busy <= 1'b1;
            else if (valid_out)
                busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_average_unpooling.sv
// Bench for average_unpooling: scratchpad model, table vectors, hand-written corner
// sequences and random jobs checked against an image-level reference model.
module tb_average_unpooling;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [3:0]  pool_size = '0;
    logic [3:0]  dimensions = '0;
    logic [11:0] input_addr = '0;
    logic [11:0] output_addr = '0;
    logic        valid_out, busy, mem_rd_en, mem_wr_en;
    logic [11:0] mem_rd_addr, mem_wr_addr;
    logic [31:0] mem_rd_data = '0;
    logic [31:0] mem_wr_data;

    average_unpooling #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DIM_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pool_size(pool_size),
        .input_addr(input_addr), .output_addr(output_addr), .dimensions(dimensions),
        .valid_out(valid_out), .busy(busy),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem  [4096];
    logic [31:0] pre  [4096];
    logic [31:0] expm [4096];
    int n_cmp = 0, n_fail = 0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, vo_cnt = 0;

    typedef struct {
        int d, p, ia, oa, lat, rd, wr;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: service the memory on the falling edge (reads return data one cycle later).
    task automatic tick();
        @(negedge clk);
        if (mem_rd_en) begin
            mem_rd_data = mem[mem_rd_addr];
            rd_cnt++;
        end
        if (mem_wr_en) begin
            mem[mem_wr_addr] = mem_wr_data;
            wr_cnt++;
        end
        if (mem_rd_en && mem_wr_en) both_cnt++;
        if (valid_out) vo_cnt++;
    endtask

    task automatic fill_mem();
        for (int k = 0; k < 4096; k++) mem[k] = $urandom;
    endtask

    task automatic start(input int d, input int p, input int ia, input int oa);
        for (int k = 0; k < 4096; k++) pre[k] = mem[k];
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0; vo_cnt = 0;
        dimensions  = 4'(d);
        pool_size   = 4'(p);
        input_addr  = 12'(ia);
        output_addr = 12'(oa);
        valid_in    = 1'b1;
    endtask

    // Latency is counted in cycles from the accepting edge to the first cycle valid_out is seen.
    task automatic run_job(input int d, input int p, input int ia, input int oa,
                           input int poke, output int lat);
        int  n;
        bit  seen;
        start(d, p, ia, oa);
        n = 0; seen = 0; lat = -1;
        while (!seen && n < 3000) begin
            tick();
            n++;
            if (valid_out) begin
                seen = 1;
                lat  = n - 1;
            end
            if (n == 1) valid_in = 1'b0;
            if (n == poke) begin
                valid_in    = 1'b1;
                dimensions  = 4'(d + 1);
                pool_size   = 4'(p + 1);
                input_addr  = 12'h007;
                output_addr = 12'h009;
            end
            if (n == poke + 1) valid_in = 1'b0;
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("busy_at_done", longint'(busy), 1);
            tick();
            chk("busy_after_done", longint'(busy), 0);
        end
        repeat (4) tick();
    endtask

    task automatic check_job(input string tag, input int d, input int p, input int ia,
                             input int oa, input int lat, input int exp_lat,
                             input int exp_rd, input int exp_wr);
        int dp, diffs;
        for (int k = 0; k < 4096; k++) expm[k] = pre[k];
        dp = d * p;
        for (int y = 0; y < dp; y++)
            for (int x = 0; x < dp; x++)
                expm[(oa + y*dp + x) % 4096] = pre[(ia + (y/p)*d + x/p) % 4096];
        diffs = 0;
        for (int k = 0; k < 4096; k++)
            if (mem[k] !== expm[k]) begin
                if (diffs == 0)
                    $display("  %s first differing word @%0h: got %0h want %0h", tag, k, mem[k], expm[k]);
                diffs++;
            end
        chk($sformatf("%s latency", tag), lat, exp_lat);
        chk($sformatf("%s reads", tag), rd_cnt, exp_rd);
        chk($sformatf("%s writes", tag), wr_cnt, exp_wr);
        chk($sformatf("%s rd_wr_overlap", tag), both_cnt, 0);
        chk($sformatf("%s done_pulses", tag), vo_cnt, 1);
        chk($sformatf("%s image_diffs", tag), diffs, 0);
    endtask

    initial begin
        int lat, rc, wc;
        int d, p, ia, oa, el, er;

        tbl[0] = '{2, 2, 'h000, 'h100, 25, 4, 16};
        tbl[1] = '{3, 1, 'h010, 'h200, 28, 9, 9};
        tbl[2] = '{4, 0, 'h300, 'h400, 1, 0, 0};
        tbl[3] = '{0, 2, 'h300, 'h400, 1, 0, 0};
        tbl[4] = '{1, 2, 'h050, 'hFFE, 7, 1, 4};

        // Reset state
        tick();
        tick();
        chk("reset_outputs",
            longint'({valid_out, busy, mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_wr_data}), 0);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 5; t++) begin
            fill_mem();
            if (t == 0) begin
                mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40;
            end
            if (t == 4) mem['h050] = 32'hDEADBEEF;
            run_job(tbl[t].d, tbl[t].p, tbl[t].ia, tbl[t].oa, -10, lat);
            check_job($sformatf("vec%0d", t), tbl[t].d, tbl[t].p, tbl[t].ia, tbl[t].oa,
                      lat, tbl[t].lat, tbl[t].rd, tbl[t].wr);
            if (t == 0) begin
                chk("t1_word_105", mem['h105], 10);
                chk("t1_word_10E", mem['h10E], 40);
            end
            if (t == 4) begin
                chk("wrap_word_FFF", mem['hFFF], 32'hDEADBEEF);
                chk("wrap_word_001", mem['h001], 32'hDEADBEEF);
            end
        end

        // Busy collision: second start at cycle 5 with different fields is dropped.
        fill_mem();
        mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40;
        run_job(2, 2, 'h000, 'h100, 5, lat);
        check_job("collision", 2, 2, 'h000, 'h100, lat, 25, 4, 16);

        // Reset mid-operation aborts the job.
        fill_mem();
        start(2, 2, 'h000, 'h100);
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 1) valid_in = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("midrst_outputs",
            longint'({valid_out, busy, mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_wr_data}), 0);
        rc = rd_cnt;
        wc = wr_cnt;
        repeat (3) tick();
        rst = 1'b0;
        repeat (40) tick();
        chk("midrst_no_reads", rd_cnt, rc);
        chk("midrst_no_writes", wr_cnt, wc);
        chk("midrst_no_done", vo_cnt, 0);
        chk("midrst_idle_busy", longint'(busy), 0);

        mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40;
        run_job(2, 2, 'h000, 'h100, -10, lat);
        check_job("after_rst", 2, 2, 'h000, 'h100, lat, 25, 4, 16);

        // Random jobs against the image-level model.
        for (int t = 0; t < 20; t++) begin
            d  = $urandom_range(0, 5);
            p  = $urandom_range(0, 4);
            ia = $urandom_range('h400, 'h6FF);
            oa = $urandom_range('h800, 'hFFF);
            el = (d == 0 || p == 0) ? 1 : d*d*(2 + p*p) + 1;
            er = (d == 0 || p == 0) ? 0 : d*d;
            fill_mem();
            run_job(d, p, ia, oa, -10, lat);
            check_job($sformatf("rnd%0d_d%0d_p%0d", t, d, p), d, p, ia, oa, lat, el, er, d*d*p*p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/average_unpooling.md
Name: average_unpooling

Overview:
- Nearest-neighbour unpooling (upsampling) engine. It is the inverse-direction companion to the average pooling engine.
- Reads a square pooled feature map of D×D words from shared memory and replicates each word into a P×P block. It writes the resulting (D·P)×(D·P) map back to memory.
- Acts as a memory master on the same single-port scratchpad and uses the same start/done handshake as the pooling block.

Parameters:
ADDR_WIDTH, 12, word address width of the scratchpad
DATA_WIDTH, 32, data word width
DIM_WIDTH, 4, width of pool_size and dimensions fields

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
valid_in  input  1  start request, sampled only in IDLE
pool_size  input  DIM_WIDTH  upsample factor P
input_addr  input  ADDR_WIDTH  base address of the pooled D×D map
output_addr  input  ADDR_WIDTH  base address of the (D·P)×(D·P) result
dimensions  input  DIM_WIDTH  pooled map side D
valid_out  output  1  one-cycle done pulse
busy  output  1  high from start accept until valid_out, inclusive
mem_rd_en  output  1  read request
mem_rd_addr  output  ADDR_WIDTH  read address
mem_rd_data  input  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
mem_wr_en  output  1  write strobe
mem_wr_addr  output  ADDR_WIDTH  write address
mem_wr_data  output  DATA_WIDTH  write data

Behaviour:
- Reset: all outputs are 0, state is IDLE, and all counters are cleared. Reset asserted mid-operation aborts the job immediately: no further reads or writes, and no valid_out.
- FSM states: IDLE, RD_REQ, RD_WAIT, WRITE, DONE.
- IDLE:
  - On valid_in=1, latch pool_size, dimensions, input_addr and output_addr, and set busy.
  - If P=0 or D=0, go to DONE; no memory traffic occurs.
  - Otherwise clear r, c, i, j and go to RD_REQ.
- RD_REQ: assert mem_rd_en for one cycle with mem_rd_addr = input_addr + r·D + c. Go to RD_WAIT.
- RD_WAIT: capture mem_rd_data into the hold register. Go to WRITE.
- WRITE: one write per cycle, P·P cycles total.
  - mem_wr_addr = output_addr + (r·P + i)·(D·P) + c·P + j
  - mem_wr_data = hold register
  - j is the inner loop and i the outer loop.
- After the last (i, j): advance c, then r, in row-major order. Return to RD_REQ, or go to DONE after element (D−1, D−1).
- DONE: valid_out=1 for exactly one cycle, busy drops in the following cycle, go to IDLE.
- Timing: valid_out rises D²·(2+P²)+1 cycles after the accepting edge. For P=0 or D=0 it rises 1 cycle after.
- Arithmetic:
  - Internal products use 2·DIM_WIDTH+ADDR_WIDTH bits.
  - Final addresses are truncated modulo 2^ADDR_WIDTH, so wrap-around past the top of memory is legal.
- valid_in while busy is ignored and does not queue. Input fields may change freely after the accept cycle.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- Data is copied bit-exact; no arithmetic is applied to data.
- valid_in high in the DONE cycle is ignored. A new start needs valid_in high in IDLE.

Test Plan:
1. Basic 2×2: mem[0x000..0x003] = 10, 20, 30, 40; D=2, P=2, input_addr=0x000, output_addr=0x100.
   - Expect writes at 0x100..0x10F with pattern rows [10,10,20,20], [10,10,20,20], [30,30,40,40], [30,30,40,40].
   - Expect exactly 16 writes and 4 reads.
   - Expect valid_out exactly 25 cycles after accept, and busy low the cycle after.
2. Identity: D=3, P=1, input 0x010, output 0x200 → mem[0x200..0x208] equals mem[0x010..0x018]; valid_out at cycle 28.
3. Degenerate: P=0 (D=4), then D=0 (P=2) → no mem_rd_en or mem_wr_en; valid_out 1 cycle after accept in each case.
4. Wrap-around: D=1, P=2, mem[0x050]=0xDEADBEEF, output_addr=0xFFE → writes to 0xFFE, 0xFFF, 0x000, 0x001, all 0xDEADBEEF.
5. Busy collision: start job 1 (D=2, P=2); pulse valid_in with different fields at cycle 5 → ignored. Outputs are identical to test 1, with a single valid_out.
6. Reset mid-operation: assert rst at cycle 10 of job 1 → all outputs 0 asynchronously, no further writes, no valid_out. A fresh start afterwards completes as in test 1.
